// File: rtl/onehot_ring_tracker.sv
`default_nettype none
// ============================================================================
// Module   : onehot_ring_tracker
// Brief    : Receive-side checker for a 3-bit one-hot ring generator
//            (000->001->010->100->000). Locks onto the sequence, decodes the
//            ring position, counts wraps, flags divergence and enable
//            starvation.
// Options  : define TRACKER_SVA_EN to compile in the embedded properties.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_ring_tracker #(
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [2:0]       state_in,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             stall
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  // Stall counter is 8 bits wide so it covers the full 1..255 range.
  localparam logic [7:0]       STALL_MAX = 8'(MAX_STALL);
  localparam logic [CNT_W-1:0] WRAP_MAX  = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] exp_val;
  logic [7:0] stall_cnt;
  logic       match;

  // Successor of a legal ring value; illegal values map to 000.
  function automatic logic [2:0] ring_next(input logic [2:0] x);
    case (x)
      3'b000:  ring_next = 3'b001;
      3'b001:  ring_next = 3'b010;
      3'b010:  ring_next = 3'b100;
      3'b100:  ring_next = 3'b000;
      default: ring_next = 3'b000;
    endcase
  endfunction

  assign match = (state_in == exp_val);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_UNLOCKED;
    else     state <= state_nxt;
  end

  // Next-state logic: clr beats every transition, ERROR only exits via clr.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_UNLOCKED;
    end else begin
      case (state)
        ST_UNLOCKED: if (state_in == 3'b000) state_nxt = ST_LOCKED;
        ST_LOCKED:   if (!match)             state_nxt = ST_ERROR;
        ST_ERROR:    state_nxt = ST_ERROR;
        default:     state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // Tracking datapath: expected value, error flags, wrap and stall counters.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      exp_val   <= 3'b000;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      wrap_cnt  <= '0;
      stall_cnt <= 8'd0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_UNLOCKED: begin
          stall_cnt <= 8'd0;
          if (state_in == 3'b000) exp_val <= en_in ? 3'b001 : 3'b000;
        end
        ST_LOCKED: begin
          if (en_in)                     stall_cnt <= 8'd0;
          else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 8'd1;
          if (match) begin
            if (en_in) exp_val <= ring_next(exp_val);
            if (en_in && exp_val == 3'b100 && wrap_cnt != WRAP_MAX)
              wrap_cnt <= wrap_cnt + 1'b1;
          end else begin
            err       <= 1'b1;
            err_pulse <= 1'b1;
          end
        end
        default: begin
          // ERROR: everything frozen until clr or rst.
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    locked = (state == ST_LOCKED);
    stall  = (stall_cnt == STALL_MAX);
    case (exp_val)
      3'b001:  phase = 2'd1;
      3'b010:  phase = 2'd2;
      3'b100:  phase = 2'd3;
      default: phase = 2'd0;
    endcase
  end

`ifdef TRACKER_SVA_EN
  a_exp_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(exp_val));
  a_pulse_err:   assert property (@(posedge clk) disable iff (rst) err_pulse |-> err);
  a_lock_noerr:  assert property (@(posedge clk) disable iff (rst) locked |-> !err);
  m_in_onehot0:  assume property (@(posedge clk) disable iff (rst) locked |-> $onehot0(state_in));
  c_wrap_two:    cover property (@(posedge clk) disable iff (rst) wrap_cnt == CNT_W'(2));
  c_stall:       cover property (@(posedge clk) disable iff (rst) stall);
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_ring_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_ring_tracker
// Brief    : Directed self-checking bench for onehot_ring_tracker; a second
//            instance with CNT_W=2 shares the stimulus to show saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_ring_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_in;
  logic [2:0] state_in;
  logic       clr;

  logic       locked, err, err_pulse, stall;
  logic [1:0] phase;
  logic [7:0] wrap_cnt;
  logic       locked2, err2, err_pulse2, stall2;
  logic [1:0] phase2;
  logic [1:0] wrap_cnt2;

  int tests = 0;
  int fails = 0;

  onehot_ring_tracker #(.CNT_W(8), .MAX_STALL(16)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .state_in(state_in), .clr(clr),
    .locked(locked), .phase(phase), .err(err), .err_pulse(err_pulse),
    .wrap_cnt(wrap_cnt), .stall(stall)
  );

  onehot_ring_tracker #(.CNT_W(2), .MAX_STALL(16)) dut2 (
    .clk(clk), .rst(rst), .en_in(en_in), .state_in(state_in), .clr(clr),
    .locked(locked2), .phase(phase2), .err(err2), .err_pulse(err_pulse2),
    .wrap_cnt(wrap_cnt2), .stall(stall2)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then look at outputs 1 ns later.
  task automatic step(input logic [2:0] s, input logic e);
    state_in = s;
    en_in    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic ring();
    step(3'b001, 1'b1);
    step(3'b010, 1'b1);
    step(3'b100, 1'b1);
    step(3'b000, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en_in = 1'b0; state_in = 3'b000;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    chk("rst_locked",    32'(locked),    32'd0);
    chk("rst_phase",     32'(phase),     32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_wrap",      32'(wrap_cnt),  32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    rst = 1'b0;

    // Lock and walk the legal sequence.
    step(3'b000, 1'b1);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_phase",  32'(phase),  32'd1);
    step(3'b001, 1'b1);  chk("seq_phase_a", 32'(phase), 32'd2);
    step(3'b010, 1'b1);  chk("seq_phase_b", 32'(phase), 32'd3);
    step(3'b100, 1'b1);
    chk("seq_phase_c", 32'(phase),    32'd0);
    chk("seq_wrap1",   32'(wrap_cnt), 32'd1);
    step(3'b000, 1'b1);  chk("seq_phase_d", 32'(phase), 32'd1);
    step(3'b001, 1'b1);
    chk("seq_phase_e", 32'(phase), 32'd2);
    chk("seq_err",     32'(err),   32'd0);
    chk("seq_locked",  32'(locked), 32'd1);

    // Mismatch with exp=010.
    step(3'b110, 1'b1);
    chk("mm_err",       32'(err),       32'd1);
    chk("mm_err_pulse", 32'(err_pulse), 32'd1);
    chk("mm_locked",    32'(locked),    32'd0);
    chk("mm_wrap",      32'(wrap_cnt),  32'd1);
    chk("mm_phase",     32'(phase),     32'd2);
    step(3'b010, 1'b1);
    chk("mm_pulse_gone", 32'(err_pulse), 32'd0);
    chk("mm_err_sticky", 32'(err),       32'd1);
    chk("mm_locked2",    32'(locked),    32'd0);
    step(3'b100, 1'b1);
    chk("err_wrap_frozen", 32'(wrap_cnt), 32'd1);
    chk("err_phase_frozen", 32'(phase),   32'd2);

    // clr in ERROR, overriding a same-cycle 000.
    clr = 1'b1;
    step(3'b000, 1'b1);
    clr = 1'b0;
    chk("clr_locked", 32'(locked),   32'd0);
    chk("clr_err",    32'(err),      32'd0);
    chk("clr_wrap",   32'(wrap_cnt), 32'd0);
    chk("clr_phase",  32'(phase),    32'd0);

    // Re-lock with enable low: exp stays 000.
    step(3'b000, 1'b0);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_phase",  32'(phase),  32'd0);

    // Enable starvation.
    for (int i = 0; i < 15; i++) step(3'b000, 1'b0);
    chk("stall_15", 32'(stall), 32'd0);
    step(3'b000, 1'b0);
    chk("stall_16", 32'(stall), 32'd1);
    step(3'b000, 1'b0);
    chk("stall_sat", 32'(stall), 32'd1);
    step(3'b000, 1'b1);
    chk("stall_fall",   32'(stall),  32'd0);
    chk("stall_phase",  32'(phase),  32'd1);
    chk("stall_locked", 32'(locked), 32'd1);

    // Five rings: 8-bit counter counts, 2-bit counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      ring();
      chk($sformatf("ring%0d_wrap8", k), 32'(wrap_cnt),  32'(k));
      chk($sformatf("ring%0d_wrap2", k), 32'(wrap_cnt2), (k > 3) ? 32'd3 : 32'(k));
    end
    chk("ring_err", 32'(err), 32'd0);

    // Reset while locked with wrap_cnt=2.
    clr = 1'b1;
    step(3'b000, 1'b1);
    clr = 1'b0;
    step(3'b000, 1'b1);
    ring();
    ring();
    chk("pre_rst_wrap",   32'(wrap_cnt), 32'd2);
    chk("pre_rst_locked", 32'(locked),   32'd1);
    rst = 1'b1; clr = 1'b1;
    step(3'b110, 1'b1);
    rst = 1'b0; clr = 1'b0;
    chk("mid_rst_locked", 32'(locked),    32'd0);
    chk("mid_rst_phase",  32'(phase),     32'd0);
    chk("mid_rst_err",    32'(err),       32'd0);
    chk("mid_rst_pulse",  32'(err_pulse), 32'd0);
    chk("mid_rst_wrap",   32'(wrap_cnt),  32'd0);
    chk("mid_rst_wrap2",  32'(wrap_cnt2), 32'd0);
    chk("mid_rst_stall",  32'(stall),     32'd0);

    // Illegal value in UNLOCKED is ignored, then 000 locks.
    step(3'b110, 1'b1);
    chk("unl_ignore_err",    32'(err),    32'd0);
    chk("unl_ignore_locked", 32'(locked), 32'd0);
    step(3'b000, 1'b1);
    chk("final_locked", 32'(locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onehot_ring_tracker.md
# onehot_ring_tracker

- Receive-side checker for the 3-bit one-hot ring generator.
- The generator output steps 000→001→010→100→000, advancing one position per clock while its enable is high.
- This block samples the generator's state and enable every cycle and keeps its own model of the expected next value.
- It locks onto the sequence, decodes the ring position, counts completed wraps, flags divergence and flags enable starvation, so a bounded check replaces the unbounded eventually-enable property.

## Interface
Parameters:
- CNT_W, 8: width of wrap counter.
- MAX_STALL, 16: consecutive enable-low cycles in LOCKED that raise `stall`; legal range 1..255.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en_in  input  1  generator enable, sampled same edge as state_in.
- state_in  input  3  generator state.
- clr  input  1  synchronous clear of tracking and error; lower priority than rst.
- locked  output  1  FSM is in LOCKED.
- phase  output  2  decode of expected value: 000→0, 001→1, 010→2, 100→3.
- err  output  1  sticky mismatch flag.
- err_pulse  output  1  one-cycle strobe on the cycle after a mismatch is detected.
- wrap_cnt  output  CNT_W  saturating count of observed 100→000 steps.
- stall  output  1  enable-starvation flag.

## Operation
- next(x): 000→001, 001→010, 010→100, 100→000. Any other value is illegal.
- FSM states: UNLOCKED, LOCKED, ERROR.
- UNLOCKED:
  - state_in==000 → LOCKED; exp <= en_in ? 001 : 000.
  - Any other state_in, legal or illegal, is ignored; no error is raised.
- LOCKED, match = (state_in==exp):
  - match: exp <= en_in ? next(exp) : exp.
  - match && en_in && exp==100: wrap_cnt <= wrap_cnt+1, saturating at all-ones.
  - !match → ERROR; err <= 1; err_pulse <= 1. exp is held.
- ERROR: exp, wrap_cnt and stall counter are frozen; state_in and en_in are ignored. Only clr or rst exits.
- clr, in any state:
  - Next state UNLOCKED; exp, err, wrap_cnt and stall counter all return to 0.
  - clr overrides a same-cycle mismatch, lock or wrap.
- Stall counter, LOCKED only:
  - en_in=1 → 0.
  - en_in=0 → +1, saturating at MAX_STALL.
  - stall = (counter==MAX_STALL).
  - Counter is forced to 0 in UNLOCKED and frozen in ERROR.
- Outputs are functions of registered state only; there is no combinational path from inputs to outputs.

## Timing
- Reset values:
  - FSM=UNLOCKED, exp=000, locked=0, phase=0.
  - err=0, err_pulse=0, wrap_cnt=0, stall=0.
- Lock latency: locked rises 1 cycle after the edge that samples state_in==000 in UNLOCKED.
- Mismatch latency: err and err_pulse rise 1 cycle after the sampling edge; err_pulse is high for exactly 1 cycle.
- Wrap latency: wrap_cnt updates 1 cycle after the edge sampling exp==100 with en_in=1.
- Stall: rises on the MAX_STALL-th consecutive en_in=0 edge in LOCKED; falls 1 cycle after the edge sampling en_in=1.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of clr or FSM state.
- Priority: rst > clr > FSM transitions.

## Configuration
- TRACKER_SVA_EN defined: embedded properties are compiled in.
  - Assert $onehot0(exp).
  - Assert err_pulse implies err.
  - Assert locked implies !err.
  - Assume $onehot0(state_in) while locked.
  - Cover wrap_cnt==2.
  - Cover stall.
- TRACKER_SVA_EN undefined: no property code is compiled; RTL behaviour is identical.

## Test plan
- Reset, then state_in=000 with en_in=1, then drive the legal sequence 001,010,100,000,001 with en_in=1 → locked=1 from cycle 2, phase 0,1,2,3,0,1, wrap_cnt=1, err=0.
- While locked with exp=010, drive state_in=110 → err_pulse=1 for exactly 1 cycle, err stays 1, locked=0, wrap_cnt frozen.
- Hold en_in=0 for 16 cycles in LOCKED with MAX_STALL=16 → stall=1 on the 16th edge; en_in=1 on the next edge → stall=0 one cycle later.
- CNT_W=2, run 5 full rings → wrap_cnt saturates at 3.
- In ERROR, assert clr for 1 cycle → UNLOCKED, err=0, wrap_cnt=0; a following 000 re-locks.
- Assert rst while LOCKED with wrap_cnt=2 → all outputs return to reset values on the next cycle.
